emergency_arbiter: RTL

- Front-end arbiter between the two emergency request sources (left and right approach) and traffic_controller.
- Detects request edges and latches them as pending.
- Issues single-cycle Emergency_Left/Emergency_Right pulses to the controller, at most one at a time.
- Enforces a hold-off window while the controller services each emergency, and breaks ties round-robin so neither side starves.

---
 rtl/traffic_pkg.sv | 21 ++
 rtl/emergency_arbiter_rise_detect.sv | 24 ++
 rtl/emergency_arbiter.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/traffic_pkg.sv
// Shared definitions for the intersection design: light encodings, side
// identifiers and the emergency arbiter state type.
package traffic_pkg;

    // Light encodings used by traffic_controller
    localparam logic [1:0] RED    = 2'b00;
    localparam logic [1:0] GREEN  = 2'b01;
    localparam logic [1:0] YELLOW = 2'b10;

    // Side identifiers; also the bit index of each side in two-bit vectors
    localparam logic LEFT  = 1'b0;
    localparam logic RIGHT = 1'b1;

    // Emergency arbiter states
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        GRANT = 2'b01,
        HOLD  = 2'b10
    } arb_state_t;

endpackage

// File: rtl/emergency_arbiter_rise_detect.sv
// Rising-edge detector for one request level: a single history register
// plus AND-NOT. Clearing the history in reset means a request held high
// through reset is reported once at the first post-reset edge.
module rise_detect (
    input  logic clk,
    input  logic rst,
    input  logic req,
    output logic rise
);

    logic req_q_reg;

    // Remember last cycle's request level
    always_ff @(posedge clk) begin
        if (rst) begin
            req_q_reg <= 1'b0;
        end else begin
            req_q_reg <= req;
        end
    end

    assign rise = req & ~req_q_reg;

endmodule

// File: rtl/emergency_arbiter.sv
// Emergency request arbiter in front of traffic_controller. Latches request
// edges as pending, issues one-cycle grant pulses one side at a time, holds
// off for HOLD_CYCLES after every grant and breaks ties round-robin.
module emergency_arbiter
    import traffic_pkg::*;
#(
    parameter int HOLD_CYCLES = 10,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             Req_Left,
    input  logic             Req_Right,
    output logic             Emergency_Left,
    output logic             Emergency_Right,
    output logic             Pending_Left,
    output logic             Pending_Right,
    output logic             Busy,
    output logic [CNT_W-1:0] Drop_Count
);

    localparam int HC_W = $clog2(HOLD_CYCLES + 1);
    localparam logic [HC_W-1:0] HOLD_LOAD = HC_W'(HOLD_CYCLES);
    localparam logic [HC_W-1:0] HOLD_LAST = HC_W'(1);

    // Per-side vectors, indexed by LEFT / RIGHT
    logic [1:0] req_vec;
    logic [1:0] rise_vec;

    assign req_vec[LEFT]  = Req_Left;
    assign req_vec[RIGHT] = Req_Right;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_rise
            rise_detect u_rise_detect (
                .clk  (clk),
                .rst  (rst),
                .req  (req_vec[gi]),
                .rise (rise_vec[gi])
            );
        end
    endgenerate

    arb_state_t       state_reg;
    logic [HC_W-1:0]  hold_cnt_reg;
    logic             rr_reg;
    logic [1:0]       pend_reg;
    logic [CNT_W-1:0] drop_cnt_reg;
    logic             em_left_reg;
    logic             em_right_reg;
    logic             busy_reg;

    logic             tie;
    logic             grant_left;
    logic             enter_grant;
    logic [1:0]       clear_vec;
    logic [1:0]       pend_next;
    logic [1:0]       drop_vec;
    logic [1:0]       drop_inc;
    logic [CNT_W:0]   drop_sum;
    logic [CNT_W-1:0] drop_cnt_next;

    // Grant decision: the sole pending side, or on a tie the side the
    // round-robin pointer did not serve last
    always_comb begin
        tie         = pend_reg[LEFT] & pend_reg[RIGHT];
        grant_left  = pend_reg[LEFT] & (~pend_reg[RIGHT] | (rr_reg == RIGHT));
        enter_grant = (|pend_reg) &
                      ((state_reg == IDLE) ||
                       ((state_reg == HOLD) && (hold_cnt_reg == HOLD_LAST)));
        clear_vec   = 2'b00;
        if (enter_grant) begin
            clear_vec[LEFT]  = grant_left;
            clear_vec[RIGHT] = ~grant_left;
        end
    end

    // Pending update and coalesced-request counting; a rise on the clearing
    // edge re-arms the side and is not counted as lost
    always_comb begin
        pend_next = (pend_reg & ~clear_vec) | rise_vec;
        drop_vec  = rise_vec & pend_reg & ~clear_vec;
        drop_inc  = {1'b0, drop_vec[LEFT]} + {1'b0, drop_vec[RIGHT]};
        drop_sum  = {1'b0, drop_cnt_reg} + (CNT_W+1)'(drop_inc);
        if (drop_sum[CNT_W]) begin
            drop_cnt_next = '1;
        end else begin
            drop_cnt_next = drop_sum[CNT_W-1:0];
        end
    end

    // Pending latches and saturating drop counter
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_reg     <= 2'b00;
            drop_cnt_reg <= '0;
        end else begin
            pend_reg     <= pend_next;
            drop_cnt_reg <= drop_cnt_next;
        end
    end

    // Arbiter FSM with hold-off counter and registered grant/busy outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            hold_cnt_reg <= '0;
            rr_reg       <= RIGHT;
            em_left_reg  <= 1'b0;
            em_right_reg <= 1'b0;
            busy_reg     <= 1'b0;
        end else begin
            em_left_reg  <= 1'b0;
            em_right_reg <= 1'b0;
            if (enter_grant) begin
                state_reg    <= GRANT;
                busy_reg     <= 1'b1;
                hold_cnt_reg <= HOLD_LOAD;
                em_left_reg  <= grant_left;
                em_right_reg <= ~grant_left;
                if (tie) begin
                    rr_reg <= grant_left ? LEFT : RIGHT;
                end
            end else begin
                case (state_reg)
                    IDLE: begin
                        busy_reg <= 1'b0;
                    end
                    GRANT: begin
                        state_reg <= HOLD;
                    end
                    HOLD: begin
                        if (hold_cnt_reg == HOLD_LAST) begin
                            state_reg <= IDLE;
                            busy_reg  <= 1'b0;
                        end else begin
                            hold_cnt_reg <= hold_cnt_reg - HC_W'(1);
                        end
                    end
                    default: begin
                        state_reg <= IDLE;
                        busy_reg  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign Emergency_Left  = em_left_reg;
    assign Emergency_Right = em_right_reg;
    assign Pending_Left    = pend_reg[LEFT];
    assign Pending_Right   = pend_reg[RIGHT];
    assign Busy            = busy_reg;
    assign Drop_Count      = drop_cnt_reg;

endmodule
